// File: rtl/fmpadding_cfg_ctrl.sv
// fmpadding_cfg_ctrl: derives fmpadding_axi registers from a frame geometry and reprograms the core at frame boundaries
module fmpadding_cfg_ctrl #(
  parameter int XCOUNTER_BITS = 8,
  parameter int YCOUNTER_BITS = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int SIMD = 2
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [XCOUNTER_BITS-1:0] cfg_xsize,
  input  logic [YCOUNTER_BITS-1:0] cfg_ysize,
  input  logic [XCOUNTER_BITS-1:0] cfg_pad_left,
  input  logic [XCOUNTER_BITS-1:0] cfg_pad_right,
  input  logic [YCOUNTER_BITS-1:0] cfg_pad_top,
  input  logic [YCOUNTER_BITS-1:0] cfg_pad_bottom,
  output logic                     cfg_err,
  output logic                     busy,
  output logic                     core_rst_n,
  output logic                     we,
  output logic [2:0]               wa,
  output logic [31:0]              wd,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic                     core_s_tvalid,
  input  logic                     core_s_tready,
  input  logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);
  localparam int CF = NUM_CHANNELS / SIMD;
  localparam int CW = XCOUNTER_BITS + YCOUNTER_BITS + $clog2(CF + 1);
  typedef enum logic [2:0] {UNCFG, DRAIN, PROG, RELEASE, RUN} state_t;
  state_t state, state_nxt;
  logic [XCOUNTER_BITS-1:0] xs, pl, pr, xs_n, pl_n, pr_n, x_hi, x_max;
  logic [YCOUNTER_BITS-1:0] ys, pt, pb, ys_n, pt_n, pb_n, y_hi, y_max;
  logic [XCOUNTER_BITS:0] x_sum;
  logic [YCOUNTER_BITS:0] y_sum;
  logic [CW-1:0] in_cnt, out_cnt, in_beats, out_beats, in_inc, out_inc, in_nxt, out_nxt, in_sz, out_sz;
  logic [2:0] step, step_nxt, wa_nxt;
  logic [31:0] wd_nxt;
  logic pending, gate, acc, bad, take, in_fire, out_fire, prog_nxt;
  assign cfg_ready = (state == UNCFG) || (state == RUN && !pending);
  assign acc = cfg_valid && cfg_ready;
  assign x_sum = {1'b0, cfg_pad_left} + {1'b0, cfg_pad_right};
  assign y_sum = {1'b0, cfg_pad_top} + {1'b0, cfg_pad_bottom};
  assign bad = (x_sum >= {1'b0, cfg_xsize}) || (y_sum >= {1'b0, cfg_ysize});
  assign take = acc && !bad;
  // Geometry seen by the write sequencer: an UNCFG accept starts writing in the same edge it is stored
  assign xs_n = take ? cfg_xsize : xs;
  assign pl_n = take ? cfg_pad_left : pl;
  assign pr_n = take ? cfg_pad_right : pr;
  assign ys_n = take ? cfg_ysize : ys;
  assign pt_n = take ? cfg_pad_top : pt;
  assign pb_n = take ? cfg_pad_bottom : pb;
  assign x_hi = xs_n - pr_n;
  assign x_max = xs_n - XCOUNTER_BITS'(1);
  assign y_hi = ys_n - pb_n;
  assign y_max = ys_n - YCOUNTER_BITS'(1);
  assign in_sz = CW'(xs - pl - pr) * CW'(ys - pt - pb) * CW'(CF);
  assign out_sz = CW'(xs) * CW'(ys) * CW'(CF);
  assign gate = (state == RUN) && !(pending && in_cnt == '0);
  assign core_s_tvalid = s_axis_tvalid && gate;
  assign s_axis_tready = core_s_tready && gate;
  assign in_fire = s_axis_tvalid && s_axis_tready;
  assign out_fire = m_axis_tvalid && m_axis_tready;
  assign in_inc = in_cnt + CW'(1);
  assign out_inc = out_cnt + CW'(1);
  assign in_nxt = !in_fire ? in_cnt : (in_inc == in_beats) ? '0 : in_inc;
  assign out_nxt = !out_fire ? out_cnt : (out_inc == out_beats) ? '0 : out_inc;
  assign step_nxt = (state == PROG) ? step + 3'd1 : 3'd0;
  assign prog_nxt = (state_nxt == PROG);
  assign wa_nxt = (step_nxt < 3'd3) ? step_nxt : step_nxt + 3'd1;
  assign wd_nxt = (step_nxt == 3'd0) ? 32'(pl_n) :
                  (step_nxt == 3'd1) ? 32'(x_hi) :
                  (step_nxt == 3'd2) ? 32'(x_max) :
                  (step_nxt == 3'd3) ? 32'(pt_n) :
                  (step_nxt == 3'd4) ? 32'(y_hi) : 32'(y_max);
  // A request landing with the frame-completing beat drains at that same boundary
  always_comb begin
    state_nxt = state;
    state_nxt = (state == UNCFG && take) ? PROG :
                (state == RUN && (pending || take) && in_nxt == '0) ? DRAIN :
                (state == DRAIN && out_cnt == '0) ? PROG :
                (state == PROG && step == 3'd5) ? RELEASE :
                (state == RELEASE) ? RUN : state;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= UNCFG;
      pending <= 1'b0;
      step <= 3'd0;
      {xs, pl, pr} <= '0;
      {ys, pt, pb} <= '0;
      in_cnt <= '0;
      out_cnt <= '0;
      in_beats <= '0;
      out_beats <= '0;
      we <= 1'b0;
      wa <= 3'd0;
      wd <= 32'd0;
      core_rst_n <= 1'b0;
      cfg_err <= 1'b0;
      busy <= 1'b1;
    end else begin
      state <= state_nxt;
      pending <= (state == RELEASE) ? 1'b0 : (state == RUN && take) ? 1'b1 : pending;
      step <= step_nxt;
      {xs, pl, pr} <= {xs_n, pl_n, pr_n};
      {ys, pt, pb} <= {ys_n, pt_n, pb_n};
      in_cnt <= (state == RELEASE) ? '0 : in_nxt;
      out_cnt <= (state == RELEASE) ? '0 : out_nxt;
      in_beats <= (state == RELEASE) ? in_sz : in_beats;
      out_beats <= (state == RELEASE) ? out_sz : out_beats;
      we <= prog_nxt;
      wa <= prog_nxt ? wa_nxt : 3'd0;
      wd <= prog_nxt ? wd_nxt : 32'd0;
      core_rst_n <= (state_nxt == RUN);
      cfg_err <= acc && bad;
      busy <= (state_nxt != RUN);
    end
  end
endmodule

// File: tb/tb_fmpadding_cfg_ctrl.sv
// tb_fmpadding_cfg_ctrl: scoreboarded register writes plus directed checks of gating, draining and reset
module tb_fmpadding_cfg_ctrl;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_ready, cfg_err, busy, core_rst_n, we;
  logic [7:0] cfg_xsize = '0, cfg_pad_left = '0, cfg_pad_right = '0;
  logic [7:0] cfg_ysize = '0, cfg_pad_top = '0, cfg_pad_bottom = '0;
  logic [2:0] wa;
  logic [31:0] wd;
  logic s_axis_tvalid = 1'b0, s_axis_tready, core_s_tvalid, core_s_tready = 1'b0;
  logic m_axis_tvalid = 1'b0, m_axis_tready = 1'b0;
  int vectors = 0, miscompares = 0;
  logic [34:0] exp_q[$];
  logic [34:0] mon_e;
  int got_in, got_out, busy_hi, rdy_hi, we_hi, wait_n;

  fmpadding_cfg_ctrl dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_xsize(cfg_xsize), .cfg_ysize(cfg_ysize), .cfg_pad_left(cfg_pad_left),
    .cfg_pad_right(cfg_pad_right), .cfg_pad_top(cfg_pad_top), .cfg_pad_bottom(cfg_pad_bottom),
    .cfg_err(cfg_err), .busy(busy), .core_rst_n(core_rst_n), .we(we), .wa(wa), .wd(wd),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .core_s_tvalid(core_s_tvalid),
    .core_s_tready(core_s_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard monitor: every write the DUT presents must match the head of the expected queue
  always @(negedge ap_clk) begin
    if (ap_rst_n && we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL write: unexpected wa=%0d wd=%0d, none expected", wa, wd);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wa, wd} !== mon_e) begin
          miscompares++;
          $display("FAIL write: got wa=%0d wd=%0d expected wa=%0d wd=%0d", wa, wd, mon_e[34:32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push6(input int a0, input int a1, input int a2, input int a4, input int a5, input int a6);
    exp_q.push_back({3'd0, 32'(a0)});
    exp_q.push_back({3'd1, 32'(a1)});
    exp_q.push_back({3'd2, 32'(a2)});
    exp_q.push_back({3'd4, 32'(a4)});
    exp_q.push_back({3'd5, 32'(a5)});
    exp_q.push_back({3'd6, 32'(a6)});
  endtask

  task automatic set_cfg(input int xs, input int ys, input int l, input int r, input int t, input int b);
    cfg_xsize = 8'(xs);
    cfg_ysize = 8'(ys);
    cfg_pad_left = 8'(l);
    cfg_pad_right = 8'(r);
    cfg_pad_top = 8'(t);
    cfg_pad_bottom = 8'(b);
  endtask

  task automatic send_cfg(input int xs, input int ys, input int l, input int r, input int t, input int b);
    @(negedge ap_clk);
    set_cfg(xs, ys, l, r, t, b);
    cfg_valid = 1'b1;
    #1 chk("cfg_ready at request", 32'(cfg_ready), 1);
    @(posedge ap_clk);
    #1 cfg_valid = 1'b0;
  endtask

  // Cycle-exact view after an accept: d extra DRAIN cycles precede the six writes
  task automatic lat_check(input int d);
    for (int j = 0; j < 8 + d; j++) begin
      @(negedge ap_clk);
      chk($sformatf("we at cycle %0d", j), 32'(we), 32'(j >= d && j < 6 + d));
      chk($sformatf("core_rst_n at cycle %0d", j), 32'(core_rst_n), 32'(j == 7 + d));
      chk($sformatf("busy at cycle %0d", j), 32'(busy), 32'(j != 7 + d));
    end
  endtask

  task automatic traffic(input int n_in, input int n_out, input int max_cyc);
    got_in = 0;
    got_out = 0;
    busy_hi = 0;
    for (int c = 0; c < max_cyc && (got_in < n_in || got_out < n_out); c++) begin
      @(negedge ap_clk);
      s_axis_tvalid = (got_in < n_in) && ($urandom_range(0, 3) != 0);
      core_s_tready = ($urandom_range(0, 3) != 0);
      m_axis_tvalid = (got_out < n_out) && ($urandom_range(0, 3) != 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      #1;
      if (busy) busy_hi++;
      if (s_axis_tvalid && s_axis_tready) got_in++;
      if (m_axis_tvalid && m_axis_tready) got_out++;
    end
    @(negedge ap_clk);
    {s_axis_tvalid, core_s_tready, m_axis_tvalid, m_axis_tready} = '0;
  endtask

  initial begin
    repeat (3) @(negedge ap_clk);
    core_s_tready = 1'b1;
    #1;
    chk("reset cfg_ready", 32'(cfg_ready), 1);
    chk("reset busy", 32'(busy), 1);
    chk("reset core_rst_n", 32'(core_rst_n), 0);
    chk("reset we", 32'(we), 0);
    chk("reset cfg_err", 32'(cfg_err), 0);
    chk("reset s_axis_tready", 32'(s_axis_tready), 0);
    core_s_tready = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Initial configuration: 10x7, L2 R3 T1 B2 -> 40 input beats, 140 output beats
    push6(2, 7, 9, 1, 5, 6);
    send_cfg(10, 7, 2, 3, 1, 2);
    lat_check(0);
    chk("queue empty after initial config", 32'(exp_q.size()), 0);

    // Two frames of stalled traffic
    traffic(80, 280, 4000);
    chk("steady input beats", 32'(got_in), 80);
    chk("steady output beats", 32'(got_out), 280);
    chk("steady busy cycles", 32'(busy_hi), 0);

    // Mid-frame reconfiguration to 8x6, pads 1 -> 48 input beats, 96 output beats
    traffic(17, 30, 1000);
    chk("mid-frame lead-in input beats", 32'(got_in), 17);
    push6(1, 7, 7, 1, 5, 5);
    send_cfg(8, 6, 1, 1, 1, 1);
    got_in = 0;
    rdy_hi = 0;
    we_hi = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge ap_clk);
      set_cfg(12, 9, 0, 4, 3, 0);
      cfg_valid = 1'b1;
      s_axis_tvalid = 1'b1;
      core_s_tready = ($urandom_range(0, 1) != 0);
      #1;
      if (s_axis_tvalid && s_axis_tready) got_in++;
      if (cfg_ready) rdy_hi++;
      if (we) we_hi++;
    end
    @(negedge ap_clk);
    s_axis_tvalid = 1'b0;
    core_s_tready = 1'b1;
    #1;
    chk("remaining input beats before gate", 32'(got_in), 23);
    chk("s_axis_tready after drain gate", 32'(s_axis_tready), 0);
    chk("cfg_ready while pending", 32'(rdy_hi), 0);
    chk("writes before output drain", 32'(we_hi), 0);
    core_s_tready = 1'b0;
    got_out = 0;
    for (int c = 0; c < 1000 && got_out < 109; c++) begin
      @(negedge ap_clk);
      m_axis_tvalid = 1'b1;
      m_axis_tready = ($urandom_range(0, 1) != 0);
      #1;
      if (m_axis_tvalid && m_axis_tready) got_out++;
      if (cfg_ready) rdy_hi++;
      if (we) we_hi++;
    end
    @(negedge ap_clk);
    chk("output beats up to 139", 32'(got_out), 109);
    chk("cfg_ready while draining", 32'(rdy_hi), 0);
    chk("writes before output beat 140", 32'(we_hi), 0);
    chk("busy before output beat 140", 32'(busy), 1);
    cfg_valid = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge ap_clk);
    {m_axis_tvalid, m_axis_tready} = '0;
    wait_n = 0;
    while (wait_n < 40 && busy) begin
      @(negedge ap_clk);
      wait_n++;
    end
    chk("busy after reprogram", 32'(busy), 0);
    chk("queue empty after reprogram", 32'(exp_q.size()), 0);

    // New geometry must be the one counted: one frame then an immediate reconfiguration
    traffic(48, 96, 3000);
    chk("new geometry input beats", 32'(got_in), 48);
    chk("new geometry busy cycles", 32'(busy_hi), 0);
    push6(0, 8, 11, 3, 9, 8);
    send_cfg(12, 9, 0, 4, 3, 0);
    lat_check(1);

    // Invalid request mid-frame: 12x9 L0 R4 T3 B0 active (96 in, 216 out)
    traffic(5, 7, 500);
    send_cfg(10, 7, 5, 5, 1, 2);
    @(negedge ap_clk);
    chk("cfg_err pulse", 32'(cfg_err), 1);
    @(negedge ap_clk);
    chk("cfg_err after pulse", 32'(cfg_err), 0);
    we_hi = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge ap_clk);
      if (we) we_hi++;
    end
    chk("writes after rejected request", 32'(we_hi), 0);
    chk("busy after rejected request", 32'(busy), 0);
    chk("cfg_ready after rejected request", 32'(cfg_ready), 1);
    traffic(91, 209, 5000);
    chk("rest of frame input beats", 32'(got_in), 91);

    // Reset during the third write of a reconfiguration
    exp_q.push_back({3'd0, 32'd2});
    exp_q.push_back({3'd1, 32'd7});
    send_cfg(10, 7, 2, 3, 1, 2);
    wait_n = 0;
    while (wait_n < 10 && !(we && wa == 3'd2)) begin
      @(posedge ap_clk);
      #1;
      wait_n++;
    end
    chk("cycles to third write", 32'(wait_n), 3);
    ap_rst_n = 1'b0;
    core_s_tready = 1'b1;
    #1;
    chk("we on reset", 32'(we), 0);
    chk("core_rst_n on reset", 32'(core_rst_n), 0);
    chk("cfg_ready on reset", 32'(cfg_ready), 1);
    chk("busy on reset", 32'(busy), 1);
    chk("s_axis_tready on reset", 32'(s_axis_tready), 0);
    chk("queue empty at reset", 32'(exp_q.size()), 0);
    core_s_tready = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    push6(2, 7, 9, 1, 5, 6);
    send_cfg(10, 7, 2, 3, 1, 2);
    lat_check(0);
    chk("queue empty at end", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
